// File: rtl/cmd_queue_if.sv
// cmd_queue_if: handshake bundle for cmd_queue.
// Carries the push side, the pop side, the synchronous flush request and the
// fill-level status. Signal names keep their io_ prefix so they line up with
// the surrounding front-end wiring.
//   slave  : the queue itself (consumes push/flush/pop_ready, drives the rest)
//   master : the producer/consumer environment (the mirror image)
interface cmd_queue_if #(
  parameter int ADDR_W  = 27,
  parameter int BURST_W = 6,
  parameter int DATA_W  = 128,
  parameter int MASK_W  = 16,
  parameter int DEPTH   = 16
);
  logic                     io_flush;
  logic                     io_push_valid;
  logic                     io_push_ready;
  logic                     io_push_cmd_type;
  logic [ADDR_W-1:0]        io_push_addr;
  logic [BURST_W-1:0]       io_push_burst_cnt;
  logic [DATA_W-1:0]        io_push_wt_data;
  logic [MASK_W-1:0]        io_push_wt_mask;
  logic                     io_pop_valid;
  logic                     io_pop_ready;
  logic                     io_pop_cmd_type;
  logic [ADDR_W-1:0]        io_pop_addr;
  logic [BURST_W-1:0]       io_pop_burst_cnt;
  logic [DATA_W-1:0]        io_pop_wt_data;
  logic [MASK_W-1:0]        io_pop_wt_mask;
  logic [$clog2(DEPTH):0]   io_level;
  logic                     io_almost_full;

  modport slave (
    input  io_flush, io_push_valid, io_push_cmd_type, io_push_addr,
           io_push_burst_cnt, io_push_wt_data, io_push_wt_mask, io_pop_ready,
    output io_push_ready, io_pop_valid, io_pop_cmd_type, io_pop_addr,
           io_pop_burst_cnt, io_pop_wt_data, io_pop_wt_mask, io_level,
           io_almost_full
  );

  modport master (
    output io_flush, io_push_valid, io_push_cmd_type, io_push_addr,
           io_push_burst_cnt, io_push_wt_data, io_push_wt_mask, io_pop_ready,
    input  io_push_ready, io_pop_valid, io_pop_cmd_type, io_pop_addr,
           io_pop_burst_cnt, io_pop_wt_data, io_pop_wt_mask, io_level,
           io_almost_full
  );
endinterface

// File: rtl/cmd_queue.sv
// cmd_queue: single-clock first-word-fall-through FIFO for DDR-style commands
// {cmd_type, addr, burst_cnt, wt_data, wt_mask} (packed MSB to LSB).
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active high (priority over flush)
//   q    - cmd_queue_if.slave: push/pop valid-ready handshakes, io_flush,
//          io_level (0..DEPTH) and io_almost_full (level >= AFULL_LVL)
// Storage is an unreset register array read asynchronously at the read
// pointer, so a pushed entry appears on the pop side one cycle later.
module cmd_queue #(
  parameter int ADDR_W    = 27,
  parameter int BURST_W   = 6,
  parameter int DATA_W    = 128,
  parameter int MASK_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input logic       clk,
  input logic       rst,
  cmd_queue_if.slave q
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_W + BURST_W + DATA_W + MASK_W;

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic               full;
  logic               empty;
  logic               push_fire;
  logic               pop_fire;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // Ready/valid depend only on stored state and flush, never on the other
  // side's handshake, so there is no combinational pop->push path.
  assign q.io_push_ready = ~full & ~q.io_flush;
  assign q.io_pop_valid  = ~empty;

  assign push_fire = q.io_push_valid & q.io_push_ready;
  // A pop during flush is not consumed; the flush discards everything anyway.
  assign pop_fire  = q.io_pop_valid & q.io_pop_ready & ~q.io_flush;

  assign push_entry = {q.io_push_cmd_type, q.io_push_addr, q.io_push_burst_cnt,
                       q.io_push_wt_data, q.io_push_wt_mask};
  assign head_entry = mem[rd_ptr[PTR_W-1:0]];

  assign {q.io_pop_cmd_type, q.io_pop_addr, q.io_pop_burst_cnt,
          q.io_pop_wt_data, q.io_pop_wt_mask} = head_entry;

  // Pointer difference modulo 2*DEPTH is exactly the occupancy 0..DEPTH.
  assign q.io_level       = wr_ptr - rd_ptr;
  assign q.io_almost_full = (q.io_level >= LVL_W'(AFULL_LVL));

  // Control: pointers
  always_ff @(posedge clk) begin
    if (rst || q.io_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Data: payload storage, left unreset
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end
endmodule

// File: tb/tb_cmd_queue.sv
// Scoreboard bench for cmd_queue: every accepted push is queued as the
// expected payload, every accepted pop is compared against the queue head,
// and status outputs are compared against the scoreboard occupancy each cycle.
module tb_cmd_queue;
  localparam int ADDR_W    = 27;
  localparam int BURST_W   = 6;
  localparam int DATA_W    = 128;
  localparam int MASK_W    = 16;
  localparam int DEPTH     = 16;
  localparam int AFULL_LVL = DEPTH - 2;
  localparam int ENTRY_W   = 1 + ADDR_W + BURST_W + DATA_W + MASK_W;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic push_valid;
  logic pop_ready;
  logic [ENTRY_W-1:0] push_e;
  logic [ENTRY_W-1:0] pop_e;

  logic [ENTRY_W-1:0] sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;

  always #5 clk = ~clk;

  cmd_queue_if #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .DATA_W(DATA_W),
                 .MASK_W(MASK_W), .DEPTH(DEPTH)) ifc ();

  cmd_queue #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .DATA_W(DATA_W),
              .MASK_W(MASK_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
    .clk (clk),
    .rst (rst),
    .q   (ifc.slave)
  );

  assign ifc.io_flush      = flush;
  assign ifc.io_push_valid = push_valid;
  assign ifc.io_pop_ready  = pop_ready;
  assign {ifc.io_push_cmd_type, ifc.io_push_addr, ifc.io_push_burst_cnt,
          ifc.io_push_wt_data, ifc.io_push_wt_mask} = push_e;
  assign pop_e = {ifc.io_pop_cmd_type, ifc.io_pop_addr, ifc.io_pop_burst_cnt,
                  ifc.io_pop_wt_data, ifc.io_pop_wt_mask};

  task automatic check(input string tag, input logic [255:0] act,
                       input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_push(input logic v, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0]  d;
    logic [MASK_W-1:0]  m;
    logic [BURST_W-1:0] b;
    d = {$urandom, $urandom, $urandom, $urandom};
    m = MASK_W'($urandom);
    b = BURST_W'($urandom);
    push_valid = v;
    push_e = {1'($urandom), addr, b, d, m};
  endtask

  // Sample mid-cycle, check status against the model, update the model with
  // the transfers that fire at the coming edge, then advance one cycle.
  task automatic step();
    bit can_push;
    bit do_pop;
    #4;
    check("level", ifc.io_level, sb.size());
    check("pop_valid", ifc.io_pop_valid, sb.size() != 0);
    check("push_ready", ifc.io_push_ready, (sb.size() < DEPTH) && !flush);
    check("almost_full", ifc.io_almost_full, sb.size() >= AFULL_LVL);
    if (rst || flush) begin
      sb.delete();
    end else begin
      can_push = (sb.size() < DEPTH) && push_valid;
      do_pop   = (sb.size() != 0) && pop_ready;
      if (do_pop) begin
        check("pop_payload", pop_e, sb[0]);
        void'(sb.pop_front());
      end
      if (can_push) begin
        sb.push_back(push_e);
        n_pushed++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int base);
    pop_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_push(1'b1, ADDR_W'(base + i));
      step();
    end
    push_valid = 1'b0;
  endtask

  task automatic drain();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    pop_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_e = '0;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    check("rst_level", ifc.io_level, 0);
    check("rst_pop_valid", ifc.io_pop_valid, 0);
    check("rst_push_ready", ifc.io_push_ready, 1);
    check("rst_afull", ifc.io_almost_full, 0);

    // Fill to full with addr 0..15, then drain in order.
    pop_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == AFULL_LVL - 1) check("t1_afull_below", ifc.io_almost_full, 0);
      if (i == AFULL_LVL)     check("t1_afull_at", ifc.io_almost_full, 1);
      set_push(1'b1, ADDR_W'(i));
      step();
    end
    push_valid = 1'b0;
    check("t1_level_full", ifc.io_level, DEPTH);
    check("t1_push_ready_full", ifc.io_push_ready, 0);
    check("t1_afull_full", ifc.io_almost_full, 1);
    pop_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t1_pop_addr", ifc.io_pop_addr, i);
      step();
    end
    check("t1_empty", ifc.io_pop_valid, 0);

    // Fall-through latency of one cycle.
    pop_ready = 1'b0;
    set_push(1'b1, ADDR_W'('h123));
    step();
    push_valid = 1'b0;
    check("t2_pop_valid", ifc.io_pop_valid, 1);
    check("t2_pop_addr", ifc.io_pop_addr, 'h123);
    step();
    check("t2_hold_addr", ifc.io_pop_addr, 'h123);
    drain();

    // Steady level 8 with simultaneous push and pop across pointer wrap.
    fill(8, 'h200);
    pop_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_push(1'b1, ADDR_W'('h300 + i));
      step();
    end
    push_valid = 1'b0;
    check("t3_level", ifc.io_level, 8);
    drain();

    // Full with pop and push together: only the pop fires.
    fill(DEPTH, 'h400);
    pop_ready = 1'b1;
    set_push(1'b1, ADDR_W'('h4ff));
    step();
    check("t4_level_after_pop", ifc.io_level, DEPTH - 1);
    check("t4_push_ready", ifc.io_push_ready, 1);
    pop_ready = 1'b0;
    step();
    push_valid = 1'b0;
    check("t4_level_refull", ifc.io_level, DEPTH);
    drain();

    // Flush at level 5 discards the concurrent push.
    fill(5, 'h500);
    flush = 1'b1;
    pop_ready = 1'b1;
    set_push(1'b1, ADDR_W'('h5ff));
    step();
    flush = 1'b0;
    pop_ready = 1'b0;
    push_valid = 1'b0;
    check("t5_level", ifc.io_level, 0);
    check("t5_pop_valid", ifc.io_pop_valid, 0);
    set_push(1'b1, ADDR_W'('h55));
    step();
    push_valid = 1'b0;
    check("t5_fresh_valid", ifc.io_pop_valid, 1);
    check("t5_fresh_addr", ifc.io_pop_addr, 'h55);
    drain();

    // Random traffic with a reset pulse halfway through.
    begin
      bit rst_done = 1'b0;
      int cycles = 0;
      n_pushed = 0;
      while (n_pushed < 10000 && cycles < 60000) begin
        cycles++;
        set_push($urandom_range(0, 99) < 60, ADDR_W'($urandom));
        pop_ready = ($urandom_range(0, 99) < 55);
        if (!rst_done && n_pushed >= 5000 && sb.size() > 2) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          rst_done = 1'b1;
          check("t6_rst_level", ifc.io_level, 0);
          check("t6_rst_pop_valid", ifc.io_pop_valid, 0);
        end else begin
          step();
        end
      end
      check("t6_completed", n_pushed >= 10000, 1);
      check("t6_rst_seen", rst_done, 1);
    end
    drain();
    check("t6_final_empty", ifc.io_pop_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
